// File: rtl/ysyx_22041461_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the
// I-cache refill path and the D-cache read/write path.
module ysyx_22041461_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_rdata,
  input  logic                d_req_valid,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic   own_d;
  logic   last_d;
  logic   pick_d;
  logic   any_req;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    pick_d  = d_req_valid & (~i_req_valid | ~last_d);
    any_req = i_req_valid | d_req_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      own_d         <= 1'b0;
      last_d        <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      i_resp_valid  <= 1'b0;
      i_resp_rdata  <= '0;
      d_resp_valid  <= 1'b0;
      d_resp_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state         <= ISSUE;
            mem_req_valid <= 1'b1;
            own_d         <= pick_d;
            last_d        <= pick_d;
            if (pick_d) begin
              mem_req_addr  <= d_req_addr;
              mem_req_wen   <= d_req_wen;
              mem_req_wdata <= d_req_wdata;
              mem_req_wmask <= d_req_wmask;
            end else begin
              mem_req_addr  <= i_req_addr;
              mem_req_wen   <= 1'b0;
              mem_req_wdata <= '0;
              mem_req_wmask <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state <= RESP;
            if (own_d) begin
              d_resp_valid <= 1'b1;
              d_resp_rdata <= mem_req_wen ? '0 : mem_resp_rdata;
            end else begin
              i_resp_valid <= 1'b1;
              i_resp_rdata <= mem_resp_rdata;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          i_resp_valid <= 1'b0;
          i_resp_rdata <= '0;
          d_resp_valid <= 1'b0;
          d_resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Directed bench for ysyx_22041461_mem_arbiter: grant order,
// field latching, stall hold, write ack and reset abandonment.
module tb_ysyx_22041461_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic [63:0] i_req_addr;
  logic        i_resp_valid;
  logic [63:0] i_resp_rdata;
  logic        d_req_valid;
  logic [63:0] d_req_addr;
  logic        d_req_wen;
  logic [63:0] d_req_wdata;
  logic [7:0]  d_req_wmask;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_22041461_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_resp_valid  (i_resp_valid),
    .i_resp_rdata  (i_resp_rdata),
    .d_req_valid   (d_req_valid),
    .d_req_addr    (d_req_addr),
    .d_req_wen     (d_req_wen),
    .d_req_wdata   (d_req_wdata),
    .d_req_wmask   (d_req_wmask),
    .d_resp_valid  (d_resp_valid),
    .d_resp_rdata  (d_resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge of an IDLE cycle with the request presented.
  // Returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input string tag,
                        input bit exp_d,
                        input logic [63:0] e_addr,
                        input logic e_wen,
                        input logic [63:0] e_wdata,
                        input logic [7:0] e_wmask,
                        input logic [63:0] rdata,
                        input int stall,
                        input int resp_dly);
    logic [63:0] e_rd;
    @(negedge clk);
    chk({tag, ".valid"}, 64'(mem_req_valid), 64'd1);
    chk({tag, ".addr"}, mem_req_addr, e_addr);
    chk({tag, ".wen"}, 64'(mem_req_wen), 64'(e_wen));
    chk({tag, ".wdata"}, mem_req_wdata, e_wdata);
    chk({tag, ".wmask"}, 64'(mem_req_wmask), 64'(e_wmask));
    for (int k = 0; k < stall; k++) begin
      mem_req_ready = 1'b0;
      d_req_addr  = d_req_addr ^ 64'hF0;
      d_req_wdata = d_req_wdata + 64'd1;
      i_req_addr  = i_req_addr + 64'd8;
      i_req_valid = ~i_req_valid;
      @(negedge clk);
      chk({tag, ".stall_valid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, ".stall_addr"}, mem_req_addr, e_addr);
      chk({tag, ".stall_wdata"}, mem_req_wdata, e_wdata);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, ".wait_valid"}, 64'(mem_req_valid), 64'd0);
    for (int k = 0; k < resp_dly; k++) begin
      @(negedge clk);
      chk({tag, ".early_resp"},
          64'(i_resp_valid | d_resp_valid), 64'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'h0;
    e_rd = e_wen ? 64'h0 : rdata;
    if (exp_d) begin
      chk({tag, ".d_resp"}, 64'(d_resp_valid), 64'd1);
      chk({tag, ".d_rdata"}, d_resp_rdata, e_rd);
      chk({tag, ".i_quiet"}, 64'(i_resp_valid), 64'd0);
    end else begin
      chk({tag, ".i_resp"}, 64'(i_resp_valid), 64'd1);
      chk({tag, ".i_rdata"}, i_resp_rdata, e_rd);
      chk({tag, ".d_quiet"}, 64'(d_resp_valid), 64'd0);
    end
    @(negedge clk);
    chk({tag, ".pulse_end"},
        64'(i_resp_valid | d_resp_valid), 64'd0);
    chk({tag, ".idle_valid"}, 64'(mem_req_valid), 64'd0);
  endtask

  initial begin
    rst            = 1'b0;
    i_req_valid    = 1'b1;
    i_req_addr     = 64'h200;
    d_req_valid    = 1'b1;
    d_req_addr     = 64'h100;
    d_req_wen      = 1'b0;
    d_req_wdata    = 64'h0;
    d_req_wmask    = 8'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'h0;

    repeat (3) @(negedge clk);
    chk("rst.mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.mem_addr", mem_req_addr, 64'd0);
    chk("rst.mem_wen", 64'(mem_req_wen), 64'd0);
    chk("rst.mem_wdata", mem_req_wdata, 64'd0);
    chk("rst.mem_wmask", 64'(mem_req_wmask), 64'd0);
    chk("rst.i_resp", 64'(i_resp_valid), 64'd0);
    chk("rst.d_resp", 64'(d_resp_valid), 64'd0);
    chk("rst.i_rdata", i_resp_rdata, 64'd0);
    chk("rst.d_rdata", d_resp_rdata, 64'd0);
    rst = 1'b1;

    // First tie after reset goes to D.
    do_txn("tie0", 1'b1, 64'h100, 1'b0, 64'h0, 8'h0,
           64'hCAFE_0001, 0, 0);

    // I read alone; D write fields present but D not valid.
    d_req_valid = 1'b0;
    d_req_wen   = 1'b1;
    d_req_wdata = 64'hFF;
    d_req_wmask = 8'hFF;
    i_req_valid = 1'b1;
    i_req_addr  = 64'h8000_0000;
    do_txn("iread", 1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h0,
           64'h1122_3344_5566_7788, 0, 1);

    // Both valid continuously: D, I, D, I.
    i_req_valid = 1'b1;
    i_req_addr  = 64'h1000;
    d_req_valid = 1'b1;
    d_req_addr  = 64'h2000;
    d_req_wen   = 1'b0;
    d_req_wdata = 64'h0;
    d_req_wmask = 8'h0;
    do_txn("rr0", 1'b1, 64'h2000, 1'b0, 64'h0, 8'h0, 64'hA0, 0, 0);
    do_txn("rr1", 1'b0, 64'h1000, 1'b0, 64'h0, 8'h0, 64'hA1, 0, 0);
    do_txn("rr2", 1'b1, 64'h2000, 1'b0, 64'h0, 8'h0, 64'hA2, 0, 0);
    do_txn("rr3", 1'b0, 64'h1000, 1'b0, 64'h0, 8'h0, 64'hA3, 0, 0);

    // D write with a 5-cycle ready stall while inputs wiggle.
    i_req_valid = 1'b0;
    d_req_valid = 1'b1;
    d_req_addr  = 64'h8000_0010;
    d_req_wen   = 1'b1;
    d_req_wdata = 64'hAA;
    d_req_wmask = 8'h01;
    do_txn("dwr", 1'b1, 64'h8000_0010, 1'b1, 64'hAA, 8'h01,
           64'hDEAD_BEEF, 5, 2);

    // Reset while in WAIT abandons the transaction.
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 64'h3000;
    @(negedge clk);
    chk("rw.issue_addr", mem_req_addr, 64'h3000);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    i_req_valid   = 1'b0;
    rst = 1'b0;
    #1;
    chk("rw.mem_addr", mem_req_addr, 64'd0);
    chk("rw.mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rw.wmask", 64'(mem_req_wmask), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h5555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray.i_resp", 64'(i_resp_valid), 64'd0);
    chk("stray.d_resp", 64'(d_resp_valid), 64'd0);
    chk("stray.rdata", i_resp_rdata | d_resp_rdata, 64'd0);
    chk("stray.mem_valid", 64'(mem_req_valid), 64'd0);

    // last_grant reset to I, so the next tie goes to D.
    i_req_valid = 1'b1;
    i_req_addr  = 64'h4000;
    d_req_valid = 1'b1;
    d_req_addr  = 64'h5000;
    d_req_wen   = 1'b0;
    @(negedge clk);
    chk("tie1.valid", 64'(mem_req_valid), 64'd1);
    chk("tie1.addr", mem_req_addr, 64'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
